lsu_mem_master: RTL and testbench

- Initiator side of the data-memory interface, in the MEM stage of the pipelined core.
- Accepts one load/store at a time from the pipeline, using RV32I funct3 encoding and byte addresses.
- Drives a word-wide, byte-enabled memory port with a req/ready handshake.
- Performs lane alignment, byte-enable generation, load sign/zero extension, optional misaligned splitting, and a bus timeout; stalls the pipeline while busy.

---
 rtl/lsu_mem_master_if.sv | 34 +++
 rtl/lsu_mem_master.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bundle of the pipeline request/response signals and the word-wide,
// byte-enabled memory port of the LSU memory master.
// master: the LSU side; slave: the pipeline/memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// LSU data-memory master (MEM stage). Takes one RV32I load/store at a time,
// drives aligned word beats with byte enables, extends load data and aborts
// a beat that waits longer than TIMEOUT cycles for mem_ready.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, accesses that
// cross a word boundary are split into two beats; when undefined, any
// misaligned halfword/word access completes immediately with rsp_err.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

  // Timeout fires in the waiting cycle whose increment would reach TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Size mask for B/H/W taken from funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Byte enables of the first word touched by the access.
  function automatic logic [3:0] lane_lo(input logic [2:0] f3, input logic [1:0] off);
    return 4'(size_mask(f3) << off);
  endfunction

  function automatic logic illegal_op(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Shift the two-word window down so the addressed byte lands in lane 0.
  function automatic logic [31:0] align_load(input logic [31:0] hi, input logic [31:0] lo,
                                             input logic [1:0] off);
    return 32'({hi, lo} >> {off, 3'b000});
  endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
  // Byte enables of the second word; non-zero means the access spans.
  function automatic logic [3:0] lane_hi(input logic [2:0] f3, input logic [1:0] off);
    return 4'(({4'b0000, size_mask(f3)} << off) >> 4);
  endfunction

  function automatic logic [31:0] wdata_hi(input logic [31:0] wd, input logic [1:0] off);
    return wd >> (6'd32 - {1'b0, off, 3'b000});
  endfunction
`else
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction
`endif

  state_t          state_q;
  logic            req_ready_q, rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
  logic [31:0]     rsp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]     wdata_q;
  logic [31:0]     lo_q;
`endif

  logic accept, reject, timeout_hit;

  assign accept      = bus.req_valid && req_ready_q;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign reject = illegal_op(bus.req_we, bus.req_funct3);
`else
  assign reject = illegal_op(bus.req_we, bus.req_funct3) ||
                  misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif

  // Capture the accepted request; these fields steer the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      off_q   <= bus.req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
      wdata_q <= bus.req_wdata;
`endif
    end
  end

  // Transaction FSM with registered handshake, memory and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (reject) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= BEAT0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_be_q    <= lane_lo(bus.req_funct3, bus.req_addr[1:0]);
              mem_wdata_q <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
              to_cnt_q    <= '0;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (lane_hi(f3_q, off_q) != 4'b0000) begin
              state_q     <= BEAT1;
              lo_q        <= bus.mem_rdata;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_be_q    <= lane_hi(f3_q, off_q);
              mem_wdata_q <= wdata_hi(wdata_q, off_q);
              to_cnt_q    <= '0;
            end else
`endif
            begin
              state_q     <= RESP;
              mem_req_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= we_q ? 32'd0
                                  : load_extend(f3_q, align_load(32'd0, bus.mem_rdata, off_q));
            end
          end else if (timeout_hit) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        BEAT1: begin
          if (bus.mem_ready) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'd0
                                : load_extend(f3_q, align_load(bus.mem_rdata, lo_q, off_q));
          end else if (timeout_hit) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
`endif
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.stall     = !req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: table of accesses with hand-computed beats and
// responses fed through scoreboard queues, plus reset sequences.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_master_if bif ();

  lsu_mem_master #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic [31:0] erd;
    logic        eerr;
    int          wn;
    int          lat;
    int          rc;
  } vec_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  vec_t  vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: programmable wait states, two overridable word locations.
  int          wait_n = 0;
  int          wcnt   = 0;
  logic [31:0] ovr_a0 = 32'hFFFF_FFF0, ovr_d0 = 32'd0;
  logic [31:0] ovr_a1 = 32'hFFFF_FFF0, ovr_d1 = 32'd0;

  assign bif.mem_ready = bif.mem_req && (wait_n >= 0) && (wcnt == wait_n);

  always_comb begin
    bif.mem_rdata = 32'h5A5A_0000 ^ bif.mem_addr;
    if (bif.mem_addr == ovr_a0)      bif.mem_rdata = ovr_d0;
    else if (bif.mem_addr == ovr_a1) bif.mem_rdata = ovr_d1;
  end

  always @(posedge clk) begin
    if (bif.mem_req && !bif.mem_ready) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any handshake seen there.
  task automatic tick();
    beat_t b;
    rsp_t  r;
    @(negedge clk);
    if (bif.mem_req && bif.mem_ready) begin
      if (beat_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL beat_unexpected: got beat at %h be %b, required none", bif.mem_addr, bif.mem_be);
      end else begin
        b = beat_q.pop_front();
        check("beat_addr", bif.mem_addr, b.addr);
        check("beat_be", {28'd0, bif.mem_be}, {28'd0, b.be});
        check("beat_we", {31'd0, bif.mem_we}, {31'd0, b.we});
        if (b.we) check("beat_wdata", bif.mem_wdata, b.wd);
      end
    end
    if (bif.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid rdata %h, required none", bif.rsp_rdata);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_rdata", bif.rsp_rdata, r.rdata);
        check("rsp_err", {31'd0, bif.rsp_err}, {31'd0, r.err});
      end
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int nb,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] rd0, input logic [31:0] a1, input logic [3:0] be1,
                              input logic [31:0] wd1, input logic [31:0] rd1,
                              input logic [31:0] erd, input logic eerr, input int wn,
                              input int lat, input int rc);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.nb = nb;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1;
    v.erd = erd; v.eerr = eerr; v.wn = wn; v.lat = lat; v.rc = rc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    beat_t b;
    rsp_t  r;
    int    lat, rc;
    logic  got;
    ovr_a0 = v.a0; ovr_d0 = v.rd0;
    ovr_a1 = v.a1; ovr_d1 = v.rd1;
    wait_n = v.wn;
    if (v.nb > 0) begin b.we = v.we; b.addr = v.a0; b.be = v.be0; b.wd = v.wd0; beat_q.push_back(b); end
    if (v.nb > 1) begin b.we = v.we; b.addr = v.a1; b.be = v.be1; b.wd = v.wd1; beat_q.push_back(b); end
    r.rdata = v.erd; r.err = v.eerr;
    rsp_q.push_back(r);
    check($sformatf("v%0d_ready_idle", idx), {31'd0, bif.req_ready}, 32'd1);
    bif.req_valid  = 1'b1;
    bif.req_we     = v.we;
    bif.req_funct3 = v.f3;
    bif.req_addr   = v.addr;
    bif.req_wdata  = v.wdata;
    tick();
    check($sformatf("v%0d_stall_busy", idx), {31'd0, bif.stall}, 32'd1);
    // Junk on the request inputs while busy must not disturb the access.
    bif.req_valid  = 1'b0;
    bif.req_we     = ~v.we;
    bif.req_funct3 = 3'b010;
    bif.req_addr   = $urandom;
    bif.req_wdata  = $urandom;
    lat = 1;
    rc  = bif.mem_req ? 1 : 0;
    got = bif.rsp_valid;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (bif.mem_req) rc++;
      got = bif.rsp_valid;
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_req_cycles", idx), rc, v.rc);
    tick();
    check($sformatf("v%0d_rsp_one_cycle", idx), {31'd0, bif.rsp_valid}, 32'd0);
    check($sformatf("v%0d_ready_after", idx), {31'd0, bif.req_ready}, 32'd1);
  endtask

  initial begin
    bif.req_valid  = 1'b0;
    bif.req_we     = 1'b0;
    bif.req_funct3 = 3'b000;
    bif.req_addr   = 32'd0;
    bif.req_wdata  = 32'd0;
    reset          = 1'b1;

    // we f3 addr wdata nb | a0 be0 wd0 rd0 | a1 be1 wd1 rd1 | erd eerr wait lat reqcyc
    vecs.push_back(mk(1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h104, 4'b1111, 32'hDEADBEEF, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 3'b000, 32'h203, 32'h000000A5, 1, 32'h200, 4'b1000, 32'hA5000000, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b000, 32'h201, 32'h0, 1, 32'h200, 4'b0010, 0, 32'h1234807F, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFFFF80, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b100, 32'h201, 32'h0, 1, 32'h200, 4'b0010, 0, 32'h1234807F, 32'hFFFF_FFF0, 0, 0, 0, 32'h00000080, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b001, 32'h102, 32'h0, 1, 32'h100, 4'b1100, 0, 32'h80011234, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF8001, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0, 1, 32'h100, 4'b1100, 0, 32'h80011234, 32'hFFFF_FFF0, 0, 0, 0, 32'h00008001, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b010, 32'h300, 32'h0, 1, 32'h300, 4'b1111, 0, 32'h44332211, 32'hFFFF_FFF0, 0, 0, 0, 32'h44332211, 0, 0, 2, 1));
    vecs.push_back(mk(1, 3'b001, 32'h106, 32'h1234BEEF, 1, 32'h104, 4'b1100, 32'hBEEF0000, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b000, 32'h007, 32'h0, 1, 32'h004, 4'b1000, 0, 32'h7F000000, 32'hFFFF_FFF0, 0, 0, 0, 32'h0000007F, 0, 0, 2, 1));
    vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 3'b100, 32'h100, 32'h55, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b111, 32'h100, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b010, 32'h400, 32'h0, 1, 32'h400, 4'b1111, 0, 32'h01020304, 32'hFFFF_FFF0, 0, 0, 0, 32'h01020304, 0, 2, 4, 3));
    vecs.push_back(mk(0, 3'b010, 32'h500, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, -1, 5, 4));
    vecs.push_back(mk(0, 3'b010, 32'h600, 32'h0, 1, 32'h600, 4'b1111, 0, 32'h0BADF00D, 32'hFFFF_FFF0, 0, 0, 0, 32'h0BADF00D, 0, 3, 5, 4));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(0, 3'b010, 32'h302, 32'h0, 2, 32'h300, 4'b1100, 0, 32'h44332211, 32'h304, 4'b0011, 0, 32'h88776655, 32'h66554433, 0, 0, 3, 2));
    vecs.push_back(mk(0, 3'b001, 32'h203, 32'h0, 2, 32'h200, 4'b1000, 0, 32'hF1000000, 32'h204, 4'b0001, 0, 32'h000000C2, 32'hFFFFC2F1, 0, 0, 3, 2));
    vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 2, 32'hFFFFFFFC, 4'b1100, 32'hF00D0000, 0, 32'h0, 4'b0011, 32'h0000CAFE, 0, 32'h0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 3'b001, 32'h101, 32'h0, 1, 32'h100, 4'b0110, 0, 32'h00ABCD00, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFFABCD, 0, 0, 2, 1));
`else
    vecs.push_back(mk(0, 3'b010, 32'h302, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b001, 32'h203, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b101, 32'h101, 32'h0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h0, 1, 0, 1, 0));
`endif

    // Reset values while reset is held.
    repeat (3) tick();
    check("rst_req_ready", {31'd0, bif.req_ready}, 32'd1);
    check("rst_stall", {31'd0, bif.stall}, 32'd0);
    check("rst_mem_req", {31'd0, bif.mem_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bif.rsp_err}, 32'd0);
    check("rst_mem_be", {28'd0, bif.mem_be}, 32'd0);

    // Idle after reset: nothing moves.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_mem_req", {31'd0, bif.mem_req}, 32'd0);
      check("idle_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // rsp_rdata/rsp_err hold their last values between responses.
    tick();
    check("hold_rsp_rdata", bif.rsp_rdata, vecs[vecs.size()-1].erd);

    // Reset during a stalled first beat: access dropped, no response.
    wait_n = -1;
    bif.req_valid  = 1'b1;
    bif.req_we     = 1'b0;
    bif.req_funct3 = 3'b010;
    bif.req_addr   = 32'h700;
    tick();
    bif.req_valid = 1'b0;
    check("midrst_beat_req", {31'd0, bif.mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_mem_req", {31'd0, bif.mem_req}, 32'd0);
    check("midrst_req_ready", {31'd0, bif.req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("postrst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
      check("postrst_mem_req", {31'd0, bif.mem_req}, 32'd0);
    end

    check("beats_left", beat_q.size(), 32'd0);
    check("rsps_left", rsp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
